// File: rtl/feistel_cipher_core_if.sv
// Handshake and data bundle for feistel_cipher_core.
// The host drives requests and out_ready; the core returns readiness, the result and status.
interface feistel_cipher_core_if #(
    parameter int WORD_W = 32
);
    logic                  start;
    logic                  in_ready;
    logic                  mode;
    logic [4*WORD_W-1:0]   plain_in;
    logic [2*WORD_W-1:0]   key_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*WORD_W-1:0]   cipher_out;
    logic                  busy;

    modport master (
        output start, mode, plain_in, key_in, out_ready,
        input  in_ready, out_valid, cipher_out, busy
    );

    modport slave (
        input  start, mode, plain_in, key_in, out_ready,
        output in_ready, out_valid, cipher_out, busy
    );
endinterface

// File: rtl/feistel_cipher_core.sv
// Iterative unbalanced-Feistel cipher, one round per clock, with a cached round-key schedule.
// Encrypt and decrypt share the datapath; decrypt just walks the round keys backwards.
module feistel_cipher_core #(
    parameter int          WORD_W  = 32,
    parameter int          ROUNDS  = 32,
    parameter int          ROT1    = 2,
    parameter int          ROT2    = 10,
    parameter logic [31:0] CK_STEP = 32'h9E3779B9
) (
    input  logic                 clock,
    input  logic                 reset,
    feistel_cipher_core_if.slave bus
);

    localparam int CNT_W = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_RUN, S_DONE} state_t;

    localparam word_t            CK_INC = CK_STEP[WORD_W-1:0];
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(ROUNDS - 1);

    function automatic word_t rotl(input word_t x, input int n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic word_t t_fn(input word_t x);
        return (x ^ rotl(x, ROT1)) + rotl(x, ROT2);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    word_t               x_q [4];
    word_t               x_d [4];
    word_t               ka_q, ka_d;
    word_t               kb_q, kb_d;
    word_t               ck_q, ck_d;
    logic [2*WORD_W-1:0] key_q, key_d;
    logic [2*WORD_W-1:0] cached_key_q, cached_key_d;
    logic                key_vld_q, key_vld_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [4*WORD_W-1:0] cipher_q, cipher_d;

    word_t               rk_q [ROUNDS];
    logic                rk_we;
    logic [CNT_W-1:0]    rk_idx;
    word_t               rk_rd;
    word_t               k_new;
    word_t               x_new;
    word_t               plain_w [4];

    // X0 sits in the most significant word of the incoming block.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign plain_w[gi] = bus.plain_in[(3-gi)*WORD_W +: WORD_W];
        end
    endgenerate

    assign rk_idx = mode_q ? (LAST - cnt_q) : cnt_q;
    assign rk_rd  = rk_q[rk_idx];
    assign k_new  = ka_q ^ t_fn(kb_q ^ ck_q);
    assign x_new  = x_q[0] ^ t_fn(x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_rd);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        x_d          = x_q;
        ka_d         = ka_q;
        kb_d         = kb_q;
        ck_d         = ck_q;
        key_d        = key_q;
        cached_key_d = cached_key_q;
        key_vld_d    = key_vld_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        cipher_d     = cipher_q;
        rk_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d     = bus.mode;
                    x_d        = plain_w;
                    key_d      = bus.key_in;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (key_vld_q && (bus.key_in == cached_key_q)) begin
                        state_d = S_RUN;
                    end else begin
                        // The schedule is about to be overwritten, so the cache stops being trustworthy now.
                        state_d   = S_KEYEXP;
                        key_vld_d = 1'b0;
                        ka_d      = bus.key_in[2*WORD_W-1:WORD_W];
                        kb_d      = bus.key_in[WORD_W-1:0];
                        ck_d      = '0;
                    end
                end
            end
            S_KEYEXP: begin
                rk_we = 1'b1;
                ka_d  = kb_q;
                kb_d  = k_new;
                ck_d  = ck_q + CK_INC;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d      = S_RUN;
                    cnt_d        = '0;
                    key_vld_d    = 1'b1;
                    cached_key_d = key_q;
                end
            end
            S_RUN: begin
                x_d[0] = x_q[1];
                x_d[1] = x_q[2];
                x_d[2] = x_q[3];
                x_d[3] = x_new;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    cipher_d    = {x_new, x_q[3], x_q[2], x_q[1]};
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            x_q          <= '{default: '0};
            ka_q         <= '0;
            kb_q         <= '0;
            ck_q         <= '0;
            key_q        <= '0;
            cached_key_q <= '0;
            key_vld_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            cipher_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            x_q          <= x_d;
            ka_q         <= ka_d;
            kb_q         <= kb_d;
            ck_q         <= ck_d;
            key_q        <= key_d;
            cached_key_q <= cached_key_d;
            key_vld_q    <= key_vld_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            cipher_q     <= cipher_d;
        end
    end

    // Round-key file needs no reset: key_vld gates every use of its contents.
    always_ff @(posedge clock) begin
        if (rk_we) begin
            rk_q[cnt_q] <= k_new;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.cipher_out = cipher_q;

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Self-checking bench for feistel_cipher_core: vector table, corner sequences, random sweep.
// Latency is counted in rising edges from the accept edge through the edge raising out_valid.
module tb_feistel_cipher_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    feistel_cipher_core_if #(.WORD_W(32)) bus_a ();
    feistel_cipher_core_if #(.WORD_W(32)) bus_z ();
    feistel_cipher_core_if #(.WORD_W(16)) bus_s ();

    feistel_cipher_core #(.WORD_W(32), .ROUNDS(32)) dut_a (.clock(clk), .reset(rst), .bus(bus_a));
    feistel_cipher_core #(.WORD_W(32), .ROUNDS(32), .CK_STEP(32'h0)) dut_z (.clock(clk), .reset(rst), .bus(bus_z));
    feistel_cipher_core #(.WORD_W(16), .ROUNDS(4)) dut_s (.clock(clk), .reset(rst), .bus(bus_s));

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic         mode;
        logic [127:0] plain;
        logic [63:0]  key;
        logic [127:0] exp;
        int           exp_lat;
        string        name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tf(input int w, input logic [63:0] x);
        logic [63:0] mask, r1, r2;
        mask = (64'd1 << w) - 64'd1;
        r1   = ((x << 2) | (x >> (w - 2))) & mask;
        r2   = ((x << 10) | (x >> (w - 10))) & mask;
        return ((x ^ r1) + r2) & mask;
    endfunction

    // Reference: full key schedule and word sequence as plain arrays.
    function automatic logic [127:0] model(input int w, input int rounds, input logic [31:0] ckstep,
                                          input logic mode, input logic [127:0] blk, input logic [63:0] key);
        logic [63:0]  mask, ck, r;
        logic [63:0]  k  [66];
        logic [63:0]  rk [64];
        logic [63:0]  x  [67];
        logic [127:0] res;
        mask = (64'd1 << w) - 64'd1;
        k[0] = (key >> w) & mask;
        k[1] = key & mask;
        for (int i = 0; i < rounds; i++) begin
            ck       = (64'(i) * 64'(ckstep)) & mask;
            k[i+2]   = k[i] ^ tf(w, (k[i+1] ^ ck) & mask);
            rk[i]    = k[i+2];
        end
        for (int j = 0; j < 4; j++) x[j] = 64'(blk >> ((3 - j) * w)) & mask;
        for (int i = 0; i < rounds; i++) begin
            r      = mode ? rk[rounds-1-i] : rk[i];
            x[i+4] = x[i] ^ tf(w, x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
        end
        res = '0;
        for (int j = 0; j < 4; j++) res = res | (128'(x[rounds+3-j]) << ((3 - j) * w));
        return res;
    endfunction

    task automatic run_op_a(input logic m, input logic [127:0] p, input logic [63:0] k,
                            output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus_a.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("a_in_ready_wait", 128'(bus_a.in_ready), 128'd1);
        bus_a.start     = 1'b1;
        bus_a.mode      = m;
        bus_a.plain_in  = p;
        bus_a.key_in    = k;
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus_a.start    = 1'b0;
        bus_a.plain_in = {$urandom, $urandom, $urandom, $urandom};
        bus_a.key_in   = {$urandom, $urandom};
        bus_a.mode     = ~m;
        guard = 0;
        while (bus_a.out_valid !== 1'b1 && guard < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            guard++;
        end
        check("a_out_valid_wait", 128'(bus_a.out_valid), 128'd1);
        res = bus_a.cipher_out;
    endtask

    initial begin
        logic [127:0] res, c0, exp;
        logic [127:0] p2, pa;
        logic [63:0]  k2, ka, kb, kc;
        logic [31:0]  pool [3];
        logic [31:0]  sk, s_key;
        logic [63:0]  sp;
        logic         sm, s_vld, exp_hit;
        int           lat, guard;

        bus_a.start = 0; bus_a.mode = 0; bus_a.plain_in = '0; bus_a.key_in = '0; bus_a.out_ready = 0;
        bus_z.start = 0; bus_z.mode = 0; bus_z.plain_in = '0; bus_z.key_in = '0; bus_z.out_ready = 0;
        bus_s.start = 0; bus_s.mode = 0; bus_s.plain_in = '0; bus_s.key_in = '0; bus_s.out_ready = 0;

        p2 = 128'h0123456789ABCDEFFEDCBA9876543210;
        k2 = 64'h0123456789ABCDEF;
        ka = {$urandom, $urandom};
        kb = ka ^ 64'h00000001_00000000;
        kc = 64'hDEADBEEF_CAFEF00D;
        pa = {$urandom, $urandom, $urandom, $urandom};

        vecs[0] = '{1'b0, p2, k2, model(32, 32, 32'h9E3779B9, 1'b0, p2, k2), 65, "enc_k2"};
        vecs[1] = '{1'b1, vecs[0].exp, k2, p2, 33, "dec_k2_hit"};
        vecs[2] = '{1'b0, pa, ka, model(32, 32, 32'h9E3779B9, 1'b0, pa, ka), 65, "enc_ka"};
        vecs[3] = '{1'b0, pa, kb, model(32, 32, 32'h9E3779B9, 1'b0, pa, kb), 65, "enc_kb"};
        vecs[4] = '{1'b0, ~pa, ka, model(32, 32, 32'h9E3779B9, 1'b0, ~pa, ka), 65, "enc_ka_again"};
        vecs[5] = '{1'b1, vecs[4].exp, ka, ~pa, 33, "dec_ka_hit"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 128'(bus_a.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus_a.out_valid), 128'd0);
        check("rst_busy", 128'(bus_a.busy), 128'd0);
        check("rst_cipher", bus_a.cipher_out, 128'd0);
        check("rst_s_in_ready", 128'(bus_s.in_ready), 128'd1);

        for (int i = 0; i < 6; i++) begin
            run_op_a(vecs[i].mode, vecs[i].plain, vecs[i].key, res, lat);
            check({vecs[i].name, "_cipher"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 128'(lat), 128'(vecs[i].exp_lat));
        end

        // Stall in DONE: result frozen, stray starts ignored.
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.plain_in = p2; bus_a.key_in = ka;
        bus_a.out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus_a.start = 1'b0;
        guard = 0;
        while (bus_a.out_valid !== 1'b1 && guard < 300) begin
            @(posedge clk); lat++; @(negedge clk); guard++;
        end
        check("stall_lat_hit", 128'(lat), 128'd33);
        c0 = bus_a.cipher_out;
        check("stall_cipher", c0, model(32, 32, 32'h9E3779B9, 1'b0, p2, ka));
        for (int i = 0; i < 10; i++) begin
            bus_a.start = 1'b1;
            bus_a.plain_in = {$urandom, $urandom, $urandom, $urandom};
            bus_a.key_in = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 128'(bus_a.out_valid), 128'd1);
            check("stall_cipher_stable", bus_a.cipher_out, c0);
            check("stall_in_ready", 128'(bus_a.in_ready), 128'd0);
        end
        bus_a.start = 1'b0;
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release_valid", 128'(bus_a.out_valid), 128'd0);
        check("stall_release_in_ready", 128'(bus_a.in_ready), 128'd1);
        check("stall_release_busy", 128'(bus_a.busy), 128'd0);

        // Reset during RUN round 16 of a key-miss op.
        bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.plain_in = p2; bus_a.key_in = kc;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (48) @(negedge clk);
        check("mid_run_busy", 128'(bus_a.busy), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 128'(bus_a.out_valid), 128'd0);
        check("mid_rst_busy", 128'(bus_a.busy), 128'd0);
        check("mid_rst_in_ready", 128'(bus_a.in_ready), 128'd1);
        check("mid_rst_cipher", bus_a.cipher_out, 128'd0);
        run_op_a(1'b0, p2, kc, res, lat);
        check("post_rst_lat_miss", 128'(lat), 128'd65);
        check("post_rst_cipher", res, model(32, 32, 32'h9E3779B9, 1'b0, p2, kc));

        // Zero round constant, zero key, zero block.
        @(negedge clk);
        bus_z.start = 1'b1; bus_z.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus_z.start = 1'b0;
        guard = 0;
        while (bus_z.out_valid !== 1'b1 && guard < 300) begin
            @(posedge clk); lat++; @(negedge clk); guard++;
        end
        check("zero_cipher", bus_z.cipher_out, 128'd0);
        check("zero_lat", 128'(lat), 128'd65);

        // Random sweep on the narrow instance.
        pool[0] = $urandom; pool[1] = $urandom; pool[2] = $urandom;
        s_vld = 1'b0;
        s_key = '0;
        for (int op = 0; op < 1000; op++) begin
            guard = 0;
            while (bus_s.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk); guard++;
            end
            check("s_in_ready", 128'(bus_s.in_ready), 128'd1);
            sm = 1'($urandom_range(0, 1));
            sp = {$urandom, $urandom};
            guard = int'($urandom_range(0, 3));
            sk = (guard == 3) ? $urandom : pool[guard];
            exp_hit = s_vld && (sk == s_key);
            s_vld = 1'b1;
            s_key = sk;
            exp = model(16, 4, 32'h9E3779B9, sm, {64'd0, sp}, {32'd0, sk});
            bus_s.start = 1'b1; bus_s.mode = sm; bus_s.plain_in = sp; bus_s.key_in = sk;
            bus_s.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            bus_s.start = 1'b0;
            bus_s.plain_in = {$urandom, $urandom};
            bus_s.key_in = $urandom;
            guard = 0;
            while (bus_s.out_valid !== 1'b1 && guard < 50) begin
                bus_s.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); lat++; @(negedge clk); guard++;
            end
            check("s_lat", 128'(lat), exp_hit ? 128'd5 : 128'd9);
            check("s_cipher", 128'(bus_s.cipher_out), {64'd0, exp[63:0]});
            if (bus_s.out_ready !== 1'b1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); @(negedge clk);
                    check("s_stall_stable", 128'(bus_s.cipher_out), {64'd0, exp[63:0]});
                end
                bus_s.out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            check("s_valid_drop", 128'(bus_s.out_valid), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
